// File: rtl/id_exe_elastic_buffer.sv
// rtl/id_exe_elastic_buffer.sv - DEPTH-entry elastic FIFO between the ID and EXE pipeline stages
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   flush        synchronous squash of every entry in flight (branch taken)
//   in_valid     ID offers in_data this cycle
//   in_ready     buffer can accept this cycle (registered-state only)
//   in_data      ID bundle, WIDTH bits
//   out_valid    head entry valid for EXE
//   out_ready    EXE consumes the head this cycle
//   out_data     head entry, all zero while out_valid is low
//   count        entries held, 0..DEPTH
//   almost_full  count >= AF_LEVEL
//   empty        count == 0
//   full         count == DEPTH

module id_exe_elastic_buffer #(
    parameter int WIDTH    = 158,
    parameter int DEPTH    = 2,
    parameter int AF_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // All status and handshake outputs decode the registered count only, so
    // there is no combinational path from out_ready to in_ready.
    assign empty       = (cnt == '0);
    assign full        = (cnt == CW'(DEPTH));
    assign almost_full = (cnt >= CW'(AF_LEVEL));
    assign in_ready    = ~full;
    assign out_valid   = ~empty;
    assign count       = cnt;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Bubble is all zeros so every downstream control bit is deasserted.
    assign out_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            // A pop in this cycle still completes for EXE, but nothing survives.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; it is only visible through out_data when non-empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_id_exe_elastic_buffer.sv
// tb/tb_id_exe_elastic_buffer.sv - self-checking bench for id_exe_elastic_buffer

module tb_id_exe_elastic_buffer;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         ir2, ov2, af2, em2, fu2;
    logic [W-1:0] od2;
    logic [1:0]   cnt2;
    logic         ir3, ov3, af3, em3, fu3;
    logic [W-1:0] od3;
    logic [1:0]   cnt3;
    logic         ir4, ov4, af4, em4, fu4;
    logic [W-1:0] od4;
    logic [2:0]   cnt4;

    id_exe_elastic_buffer #(.WIDTH(W), .DEPTH(2), .AF_LEVEL(1)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .count(cnt2), .almost_full(af2), .empty(em2), .full(fu2)
    );

    id_exe_elastic_buffer #(.WIDTH(W), .DEPTH(3), .AF_LEVEL(2)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
        .count(cnt3), .almost_full(af3), .empty(em3), .full(fu3)
    );

    id_exe_elastic_buffer #(.WIDTH(W), .DEPTH(4), .AF_LEVEL(3)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .count(cnt4), .almost_full(af4), .empty(em4), .full(fu4)
    );

    logic         ov_a [3];
    logic [W-1:0] od_a [3];
    logic [2:0]   cnt_a [3];
    logic         ir_a [3];
    logic         af_a [3];
    logic         em_a [3];
    logic         fu_a [3];

    assign ov_a[0] = ov2;  assign ov_a[1] = ov3;  assign ov_a[2] = ov4;
    assign od_a[0] = od2;  assign od_a[1] = od3;  assign od_a[2] = od4;
    assign cnt_a[0] = {1'b0, cnt2};
    assign cnt_a[1] = {1'b0, cnt3};
    assign cnt_a[2] = cnt4;
    assign ir_a[0] = ir2;  assign ir_a[1] = ir3;  assign ir_a[2] = ir4;
    assign af_a[0] = af2;  assign af_a[1] = af3;  assign af_a[2] = af4;
    assign em_a[0] = em2;  assign em_a[1] = em3;  assign em_a[2] = em4;
    assign fu_a[0] = fu2;  assign fu_a[1] = fu3;  assign fu_a[2] = fu4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Vector: inputs for the cycle, then the outputs expected during that
    // cycle (all outputs are registered-state functions) for the DEPTH=2 instance.
    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         ov;
        logic [W-1:0] od;
        logic [1:0]   cnt;
        logic         ir;
        logic         fu;
        logic         af;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl,
                                input logic ov, input logic [W-1:0] od, input logic [1:0] cnt,
                                input logic ir, input logic fu, input logic af);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.cnt = cnt; v.ir = ir; v.fu = fu; v.af = af;
        return v;
    endfunction

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    vec_t vt [22];
    logic [W-1:0] mq [3][$];
    int dep [3];
    int afl [3];

    initial begin
        dep[0] = 2; dep[1] = 3; dep[2] = 4;
        afl[0] = 1; afl[1] = 2; afl[2] = 3;

        //           iv  data      ordy fl   ov  od        cnt   ir fu af
        // latency
        vt[0]  = mk(H, 16'h00A5, H, L,   L, 16'h0000, 2'd0, H, L, L);
        vt[1]  = mk(L, 16'h0000, H, L,   H, 16'h00A5, 2'd1, H, L, H);
        vt[2]  = mk(L, 16'h0000, L, L,   L, 16'h0000, 2'd0, H, L, L);
        // back-pressure: 3 held off while full, then order 1,2,3
        vt[3]  = mk(H, 16'h0001, L, L,   L, 16'h0000, 2'd0, H, L, L);
        vt[4]  = mk(H, 16'h0002, L, L,   H, 16'h0001, 2'd1, H, L, H);
        vt[5]  = mk(H, 16'h0003, L, L,   H, 16'h0001, 2'd2, L, H, H);
        vt[6]  = mk(H, 16'h0003, L, L,   H, 16'h0001, 2'd2, L, H, H);
        vt[7]  = mk(H, 16'h0003, H, L,   H, 16'h0001, 2'd2, L, H, H);
        vt[8]  = mk(H, 16'h0003, H, L,   H, 16'h0002, 2'd1, H, L, H);
        vt[9]  = mk(L, 16'h0000, H, L,   H, 16'h0003, 2'd1, H, L, H);
        vt[10] = mk(L, 16'h0000, L, L,   L, 16'h0000, 2'd0, H, L, L);
        // flush while full with in_valid high
        vt[11] = mk(H, 16'h0011, L, L,   L, 16'h0000, 2'd0, H, L, L);
        vt[12] = mk(H, 16'h0022, L, L,   H, 16'h0011, 2'd1, H, L, H);
        vt[13] = mk(H, 16'h0033, L, H,   H, 16'h0011, 2'd2, L, H, H);
        // flush with an accepted push and a pop in the same cycle
        vt[14] = mk(H, 16'h0044, L, L,   L, 16'h0000, 2'd0, H, L, L);
        vt[15] = mk(H, 16'h0055, H, H,   H, 16'h0044, 2'd1, H, L, H);
        vt[16] = mk(L, 16'h0000, H, L,   L, 16'h0000, 2'd0, H, L, L);
        // valid hold under out_ready=0
        vt[17] = mk(H, 16'h0066, H, L,   L, 16'h0000, 2'd0, H, L, L);
        vt[18] = mk(L, 16'h0000, L, L,   H, 16'h0066, 2'd1, H, L, H);
        vt[19] = mk(L, 16'h0000, L, L,   H, 16'h0066, 2'd1, H, L, H);
        vt[20] = mk(L, 16'h0000, H, L,   H, 16'h0066, 2'd1, H, L, H);
        vt[21] = mk(L, 16'h0000, L, L,   L, 16'h0000, 2'd0, H, L, L);

        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'h0077; out_ready = 1'b1;

        // reset held with in_valid high: nothing may enter
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("reset_state", {ov2, od2, cnt2, ir2, em2, fu2, af2},
                {1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("after_release", {ov2, od2, cnt2, ir2, em2}, {1'b0, 16'h0000, 2'd0, 1'b1, 1'b1});

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy; flush = vt[i].fl;
            #1;
            chk($sformatf("vec[%0d]", i), {ov2, od2, cnt2, ir2, fu2, af2, em2},
                {vt[i].ov, vt[i].od, vt[i].cnt, vt[i].ir, vt[i].fu, vt[i].af, ~vt[i].ov});
        end

        // steady stream through DEPTH=3: count stays 1, output trails input by one cycle
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = W'(16'h0100 + k);
            #1;
            if (k == 0) begin
                chk("stream_start", {ov3, cnt3}, {1'b0, 2'd0});
            end else begin
                chk($sformatf("stream[%0d]", k), {ov3, od3, cnt3}, {1'b1, W'(16'h0100 + k - 1), 2'd1});
            end
        end

        // random traffic against a reference queue per depth
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = W'($urandom);
            if (k == 0) flush = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                int sz;
                logic pu, po;
                sz = mq[i].size();
                chk($sformatf("rnd_d%0d", dep[i]),
                    {ov_a[i], od_a[i], cnt_a[i], ir_a[i], em_a[i], fu_a[i], af_a[i]},
                    {(sz > 0), (sz > 0) ? mq[i][0] : 16'h0000, 3'(sz), (sz < dep[i]),
                     (sz == 0), (sz == dep[i]), (sz >= afl[i])});
                pu = in_valid && (sz < dep[i]);
                po = out_ready && (sz > 0);
                if (flush) begin
                    mq[i].delete();
                end else begin
                    if (po) void'(mq[i].pop_front());
                    if (pu) mq[i].push_back(in_data);
                end
            end
        end

        // asynchronous reset between clock edges while holding data
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; in_data = 16'h0BEE;
        @(negedge clk);
        in_data = 16'h0BEF;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_async_rst", {ov2, od2, cnt2}, {1'b1, 16'h0BEE, 2'd2});
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst", {ov2, od2, cnt2, ir2, em2, fu2, af2, cnt4, ov4},
            {1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_async_rst", {ov2, cnt2, ov3, cnt3}, {1'b0, 2'd0, 1'b0, 2'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
